// File: rtl/enemy_fire_pkg.sv
// Shared types and defaults for the enemy fire scheduler and its round-robin picker.
// Optional cooldown escalation is enabled by defining ENEMY_FIRE_ESCALATE_EN.
package enemy_fire_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      COOL = 2'd1,
      PICK = 2'd2,
      FIRE = 2'd3
   } sched_state_t;

   localparam int ENEMY_COOLDOWN_FRAMES = 60;
   localparam int ENEMY_FLIGHT_FRAMES   = 90;

   // Index width for an n-entry pointer; never narrower than one bit.
   function automatic int ptr_width(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/enemy_fire_scheduler_rr_picker.sv
// Combinational round-robin first-one search: lowest eligible index at or above ptr_i,
// wrapping to the lowest eligible index overall.
module rr_picker
   import enemy_fire_pkg::*;
#(
   parameter int N     = 2,
   parameter int PTR_W = ptr_width(N)
) (
   input  logic [N-1:0]     eligible_i,
   input  logic [PTR_W-1:0] ptr_i,
   output logic [PTR_W-1:0] winner_o,
   output logic             valid_o
);

   logic [N-1:0] upper_mask;
   logic [N-1:0] upper;
   logic [N-1:0] search;

   generate
      for (genvar gi = 0; gi < N; gi++) begin : g_mask
         assign upper_mask[gi] = (PTR_W'(gi) >= ptr_i);
      end
   endgenerate

   assign upper   = eligible_i & upper_mask;
   assign search  = (|upper) ? upper : eligible_i;
   assign valid_o = |eligible_i;

   always_comb begin
      winner_o = '0;
      for (int i = N - 1; i >= 0; i--) begin
         if (search[i]) winner_o = PTR_W'(i);
      end
   end

endmodule

// File: rtl/enemy_fire_scheduler.sv
// Frame-rate enemy shot scheduler: cooldown, round-robin base selection, shot lifetimes.
// Define ENEMY_FIRE_ESCALATE_EN to halve the cooldown when only one base remains alive.
module enemy_fire_scheduler
   import enemy_fire_pkg::*;
#(
   parameter int NUM_BASES       = 2,
   parameter int COOLDOWN_FRAMES = ENEMY_COOLDOWN_FRAMES,
   parameter int FLIGHT_FRAMES   = ENEMY_FLIGHT_FRAMES,
   parameter int MAX_ACTIVE      = 1
) (
   input  logic                             frame_clk,
   input  logic                             Reset_n,
   input  logic                             enable,
   input  logic [NUM_BASES-1:0]             base_alive,
   input  logic [NUM_BASES-1:0]             base_in_range,
   input  logic [NUM_BASES-1:0]             bullet_done,
   output logic [NUM_BASES-1:0]             fire_grant,
   output logic [NUM_BASES-1:0]             bullet_active,
   output logic [$clog2(NUM_BASES+1)-1:0]   active_count,
   output logic [1:0]                       sched_state
);

   localparam int CD_W   = $clog2(COOLDOWN_FRAMES + 1);
   localparam int LIFE_W = $clog2(FLIGHT_FRAMES + 1);
   localparam int RR_W   = ptr_width(NUM_BASES);
   localparam int CNT_W  = $clog2(NUM_BASES + 1);

   sched_state_t          state_q, state_d;
   logic [CD_W-1:0]       cooldown_q, cooldown_d;
   logic [RR_W-1:0]       rr_ptr_q, rr_ptr_d;
   logic [RR_W-1:0]       winner_q, winner_d;
   logic [NUM_BASES-1:0]  fire_grant_q, fire_grant_d;

   logic [NUM_BASES-1:0]  active_vec;
   logic [NUM_BASES-1:0]  eligible;
   logic [RR_W-1:0]       pick_winner;
   logic                  pick_valid;
   logic [CNT_W-1:0]      count;
   logic                  can_issue;
   logic                  fire_exit;
   logic [CD_W-1:0]       reload;
   logic [CD_W-1:0]       reload_m1;

`ifdef ENEMY_FIRE_ESCALATE_EN
   localparam int ESC_FRAMES = ((COOLDOWN_FRAMES >> 1) < 1) ? 1 : (COOLDOWN_FRAMES >> 1);
   logic last_base;

   // Exactly one bit set: nonzero and clearing the lowest set bit leaves nothing.
   assign last_base = (base_alive != '0) &&
                      ((base_alive & (base_alive - NUM_BASES'(1))) == '0);
   assign reload    = last_base ? CD_W'(ESC_FRAMES) : CD_W'(COOLDOWN_FRAMES);
`else
   assign reload    = CD_W'(COOLDOWN_FRAMES);
`endif

   assign reload_m1 = reload - CD_W'(1);
   assign eligible  = base_alive & base_in_range & ~active_vec;

   rr_picker #(
      .N     (NUM_BASES),
      .PTR_W (RR_W)
   ) u_rr_picker (
      .eligible_i (eligible),
      .ptr_i      (rr_ptr_q),
      .winner_o   (pick_winner),
      .valid_o    (pick_valid)
   );

   always_comb begin
      count = '0;
      for (int i = 0; i < NUM_BASES; i++) begin
         count = count + CNT_W'(active_vec[i]);
      end
   end

   assign can_issue = (count < CNT_W'(MAX_ACTIVE));

   always_comb begin
      state_d      = state_q;
      cooldown_d   = cooldown_q;
      rr_ptr_d     = rr_ptr_q;
      winner_d     = winner_q;
      fire_grant_d = '0;
      fire_exit    = 1'b0;
      if (!enable) begin
         state_d = IDLE;
      end else begin
         case (state_q)
            IDLE: begin
               state_d    = COOL;
               cooldown_d = reload_m1;
            end
            COOL: begin
               if (cooldown_q == '0) state_d = PICK;
               else                  cooldown_d = cooldown_q - CD_W'(1);
            end
            PICK: begin
               if (pick_valid && can_issue) begin
                  winner_d     = pick_winner;
                  fire_grant_d = NUM_BASES'(1) << pick_winner;
                  state_d      = FIRE;
               end
            end
            FIRE: begin
               fire_exit  = 1'b1;
               rr_ptr_d   = (winner_q == RR_W'(NUM_BASES - 1)) ? '0 : winner_q + RR_W'(1);
               cooldown_d = reload_m1;
               state_d    = COOL;
            end
            default: state_d = IDLE;
         endcase
      end
   end

   always_ff @(posedge frame_clk or negedge Reset_n) begin
      if (!Reset_n) begin
         state_q      <= IDLE;
         cooldown_q   <= '0;
         rr_ptr_q     <= '0;
         winner_q     <= '0;
         fire_grant_q <= '0;
      end else begin
         state_q      <= state_d;
         cooldown_q   <= cooldown_d;
         rr_ptr_q     <= rr_ptr_d;
         winner_q     <= winner_d;
         fire_grant_q <= fire_grant_d;
      end
   end

   // Per-base shot lifetime; a launch on the FIRE exit edge overrides any kill condition.
   generate
      for (genvar gi = 0; gi < NUM_BASES; gi++) begin : g_life
         logic              active_q, active_d;
         logic [LIFE_W-1:0] life_q, life_d;
         logic              launch;

         assign launch = fire_exit && (winner_q == RR_W'(gi));

         always_comb begin
            active_d = active_q;
            life_d   = life_q;
            if (!enable) begin
               active_d = 1'b0;
               life_d   = '0;
            end else if (launch) begin
               active_d = 1'b1;
               life_d   = LIFE_W'(FLIGHT_FRAMES - 1);
            end else if (active_q) begin
               if ((life_q == '0) || bullet_done[gi] || !base_alive[gi]) begin
                  active_d = 1'b0;
                  life_d   = '0;
               end else begin
                  life_d = life_q - LIFE_W'(1);
               end
            end
         end

         always_ff @(posedge frame_clk or negedge Reset_n) begin
            if (!Reset_n) begin
               active_q <= 1'b0;
               life_q   <= '0;
            end else begin
               active_q <= active_d;
               life_q   <= life_d;
            end
         end

         assign active_vec[gi] = active_q;
      end
   endgenerate

   assign fire_grant    = fire_grant_q;
   assign bullet_active = active_vec;
   assign active_count  = count;
   assign sched_state   = state_q;

endmodule
